// File: rtl/pc_redirect.sv
// Control-flow resolution between decode and the program counter: computes branch/jump
// targets, sequences the post-redirect squash, holds halt after a halting syscall.
module pc_redirect #(
    parameter int WORD_SIZE    = 32,
    parameter int FLUSH_CYCLES = 1,
    parameter int HALT_CODE    = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] pc_cur,
    input  logic                 id_valid,
    input  logic                 is_beq,
    input  logic                 is_bne,
    input  logic                 is_j,
    input  logic                 is_jal,
    input  logic                 is_jr,
    input  logic                 is_syscall,
    input  logic [WORD_SIZE-1:0] rs_val,
    input  logic [WORD_SIZE-1:0] rt_val,
    input  logic [WORD_SIZE-1:0] v0_val,
    input  logic [15:0]          imm16,
    input  logic [25:0]          target26,
    input  logic                 resume,
    output logic                 pc_bj,
    output logic [WORD_SIZE-1:0] pc_target,
    output logic                 halt,
    output logic                 flush,
    output logic                 link_we,
    output logic [WORD_SIZE-1:0] link_addr,
    output logic [31:0]          branch_count
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    function automatic logic [WORD_SIZE-1:0] sign_ext16(input logic [15:0] v);
        return {{(WORD_SIZE-16){v[15]}}, v};
    endfunction

    state_t                 state_r, state_s;
    logic [3:0]             flush_cnt_r, flush_cnt_s;
    logic                   halt_r, flush_r, link_we_r;
    logic [WORD_SIZE-1:0]   link_addr_r;
    logic [31:0]            count_r;

    logic [WORD_SIZE-1:0]   pc1_s;
    logic                   accept_s, halt_req_s, take_s, link_s;

    assign pc1_s      = pc_cur + {{(WORD_SIZE-1){1'b0}}, 1'b1};
    assign accept_s   = id_valid && (state_r == ST_RUN) && !rst;
    assign halt_req_s = accept_s && is_syscall && (v0_val == WORD_SIZE'(HALT_CODE));

    // Decode priority and target selection: syscall > jr > j/jal > beq/bne.
    always_comb begin
        take_s    = 1'b0;
        link_s    = 1'b0;
        pc_target = pc1_s;
        if (rst) begin
            pc_target = {WORD_SIZE{1'b0}};
        end else if (accept_s && !is_syscall) begin
            if (is_jr) begin
                take_s    = 1'b1;
                pc_target = {2'b00, rs_val[WORD_SIZE-1:2]};
            end else if (is_j || is_jal) begin
                take_s    = 1'b1;
                link_s    = is_jal;
                pc_target = {pc1_s[WORD_SIZE-1:26], target26};
            end else if ((is_beq && (rs_val == rt_val)) || (is_bne && (rs_val != rt_val))) begin
                take_s    = 1'b1;
                pc_target = pc1_s + sign_ext16(imm16);
            end else begin
                take_s    = 1'b0;
            end
        end else begin
            take_s = 1'b0;
        end
        pc_bj = take_s;
    end

    // Next-state logic for the RUN / FLUSH / HALTED sequencer.
    always_comb begin
        state_s     = state_r;
        flush_cnt_s = flush_cnt_r;
        case (state_r)
            ST_RUN: begin
                if (halt_req_s) begin
                    state_s = ST_HALTED;
                end else if (take_s) begin
                    state_s     = ST_FLUSH;
                    flush_cnt_s = 4'(FLUSH_CYCLES - 1);
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_r == 4'd0) begin
                    state_s = ST_RUN;
                end else begin
                    flush_cnt_s = flush_cnt_r - 4'd1;
                end
            end
            ST_HALTED: begin
                if (resume) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_HALTED;
                end
            end
            default: begin
                state_s     = ST_RUN;
                flush_cnt_s = 4'd0;
            end
        endcase
    end

    // State, registered outputs and the saturating redirect counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_RUN;
            flush_cnt_r <= 4'd0;
            halt_r      <= 1'b0;
            flush_r     <= 1'b0;
            link_we_r   <= 1'b0;
            link_addr_r <= {WORD_SIZE{1'b0}};
            count_r     <= 32'd0;
        end else begin
            state_r     <= state_s;
            flush_cnt_r <= flush_cnt_s;
            halt_r      <= (state_s == ST_HALTED);
            flush_r     <= (state_s == ST_FLUSH);
            link_we_r   <= take_s && link_s;
            if (take_s && link_s) begin
                link_addr_r <= pc1_s;
            end
            if (take_s && (count_r != 32'hFFFF_FFFF)) begin
                count_r <= count_r + 32'd1;
            end
        end
    end

    assign halt         = halt_r;
    assign flush        = flush_r;
    assign link_we      = link_we_r;
    assign link_addr    = link_addr_r;
    assign branch_count = count_r;

endmodule

// File: tb/tb_pc_redirect.sv
// Scoreboard bench for pc_redirect: a reference model predicts combinational and
// registered outputs each cycle; registered expectations are queued and compared after the edge.
module tb_pc_redirect;
    localparam int WS = 32;
    localparam int FC = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [WS-1:0] pc_cur, rs_val, rt_val, v0_val;
    logic          id_valid, is_beq, is_bne, is_j, is_jal, is_jr, is_syscall, resume;
    logic [15:0]   imm16;
    logic [25:0]   target26;
    logic          pc_bj, halt, flush, link_we;
    logic [WS-1:0] pc_target, link_addr;
    logic [31:0]   branch_count;

    always #5 clk = ~clk;

    pc_redirect #(.WORD_SIZE(WS), .FLUSH_CYCLES(FC), .HALT_CODE(10)) dut (
        .clk(clk), .rst(rst), .pc_cur(pc_cur), .id_valid(id_valid),
        .is_beq(is_beq), .is_bne(is_bne), .is_j(is_j), .is_jal(is_jal),
        .is_jr(is_jr), .is_syscall(is_syscall), .rs_val(rs_val), .rt_val(rt_val),
        .v0_val(v0_val), .imm16(imm16), .target26(target26), .resume(resume),
        .pc_bj(pc_bj), .pc_target(pc_target), .halt(halt), .flush(flush),
        .link_we(link_we), .link_addr(link_addr), .branch_count(branch_count)
    );

    typedef struct {
        logic        halt;
        logic        flush;
        logic        link_we;
        logic [31:0] link_addr;
        logic [31:0] count;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          flush_seen = 0;
    int          m_state = 0;   // 0 run, 1 flush, 2 halted
    int          m_left = 0;
    logic [31:0] m_count = 32'd0;
    logic [31:0] m_link_addr = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        id_valid = 1'b1; is_beq = 1'b0; is_bne = 1'b0; is_j = 1'b0; is_jal = 1'b0;
        is_jr = 1'b0; is_syscall = 1'b0; resume = 1'b0;
    endtask

    task automatic step();
        logic [31:0] pc1, tgt, exp_tgt;
        logic        acc, hreq, taken, link;
        exp_t        e, o;
        @(negedge clk);
        pc1 = pc_cur + 32'd1; tgt = pc1; taken = 1'b0; link = 1'b0;
        acc  = !rst && id_valid && (m_state == 0);
        hreq = acc && is_syscall && (v0_val == 32'd10);
        if (acc && !is_syscall) begin
            if (is_jr) begin
                taken = 1'b1; tgt = rs_val >> 2;
            end else if (is_j || is_jal) begin
                taken = 1'b1; link = is_jal; tgt = {pc1[31:26], target26};
            end else if ((is_beq && rs_val == rt_val) || (is_bne && rs_val != rt_val)) begin
                taken = 1'b1; tgt = pc1 + {{16{imm16[15]}}, imm16};
            end
        end
        exp_tgt = rst ? 32'd0 : (taken ? tgt : pc1);
        check("pc_bj", {31'd0, pc_bj}, {31'd0, taken});
        check("pc_target", pc_target, exp_tgt);
        e.link_we = 1'b0;
        if (rst) begin
            m_state = 0; m_left = 0; m_count = 32'd0; m_link_addr = 32'd0;
        end else begin
            if (link) m_link_addr = pc1;
            e.link_we = link;
            case (m_state)
                0: begin
                    if (hreq) m_state = 2;
                    else if (taken) begin
                        m_state = 1; m_left = FC;
                        if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
                    end
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_state = 0;
                end
                2: if (resume) m_state = 0;
                default: m_state = 0;
            endcase
        end
        e.halt = (m_state == 2); e.flush = (m_state == 1);
        e.link_addr = m_link_addr; e.count = m_count;
        sb.push_back(e);
        @(posedge clk); #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            o = sb.pop_front();
            check("halt", {31'd0, halt}, {31'd0, o.halt});
            check("flush", {31'd0, flush}, {31'd0, o.flush});
            check("link_we", {31'd0, link_we}, {31'd0, o.link_we});
            check("link_addr", link_addr, o.link_addr);
            check("branch_count", branch_count, o.count);
        end
        if (flush) flush_seen++;
    endtask

    task automatic wait_idle(input int n);
        idle();
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1; pc_cur = 32'd0; rs_val = 32'd0; rt_val = 32'd0; v0_val = 32'd0;
        imm16 = 16'd0; target26 = 26'd0;
        idle(); id_valid = 1'b0;
        step(); step();
        rst = 1'b0;

        // plain fall-through
        idle(); pc_cur = 32'd5; step();

        // taken beq, flush duration
        pc_cur = 32'h10; rs_val = 32'd7; rt_val = 32'd7; imm16 = 16'hFFFE; is_beq = 1'b1;
        flush_seen = 0;
        step();
        wait_idle(FC + 2);
        check("flush_len", flush_seen, FC);
        check("count_after_beq", branch_count, 32'd1);

        // bne with equal operands: not taken
        is_bne = 1'b1; step();

        // jal and link pulse
        idle(); pc_cur = 32'h0400_0003; target26 = 26'h0000123; is_jal = 1'b1; step();
        check("jal_link_addr", link_addr, 32'h0400_0004);
        wait_idle(FC + 1);

        // jr
        is_jr = 1'b1; rs_val = 32'h40; step();
        wait_idle(FC + 1);

        // halting syscall with is_j also set
        is_syscall = 1'b1; is_j = 1'b1; v0_val = 32'd10; step();
        for (int i = 0; i < 20; i++) begin
            is_j = 1'($urandom_range(0, 1)); is_beq = 1'($urandom_range(0, 1));
            rs_val = 32'($urandom_range(0, 3)); rt_val = 32'($urandom_range(0, 3));
            step();
        end
        check("halt_held", {31'd0, halt}, 32'd1);
        idle(); resume = 1'b1; step();
        resume = 1'b0; step();

        // non-halting syscall
        is_syscall = 1'b1; v0_val = 32'd4; step();

        // halting syscall during FLUSH is squashed
        idle(); is_j = 1'b1; step();
        idle(); is_syscall = 1'b1; v0_val = 32'd10; step();
        wait_idle(FC + 1);
        check("squashed_halt", {31'd0, halt}, 32'd0);

        // reset while HALTED
        is_syscall = 1'b1; v0_val = 32'd10; step();
        idle(); rst = 1'b1; step(); rst = 1'b0; step();

        // reset mid-FLUSH
        is_j = 1'b1; step();
        idle(); step();
        rst = 1'b1; step(); rst = 1'b0; step();

        // saturation
        dut.count_r = 32'hFFFF_FFFF;
        m_count = 32'hFFFF_FFFF;
        is_j = 1'b1; step();
        wait_idle(FC + 1);
        check("count_sat", branch_count, 32'hFFFF_FFFF);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            rst        = ($urandom_range(0, 49) == 0);
            id_valid   = ($urandom_range(0, 3) != 0);
            is_beq     = ($urandom_range(0, 5) == 0);
            is_bne     = ($urandom_range(0, 5) == 0);
            is_j       = ($urandom_range(0, 7) == 0);
            is_jal     = ($urandom_range(0, 7) == 0);
            is_jr      = ($urandom_range(0, 7) == 0);
            is_syscall = ($urandom_range(0, 11) == 0);
            resume     = ($urandom_range(0, 7) == 0);
            v0_val     = ($urandom_range(0, 1) == 0) ? 32'd10 : 32'd4;
            rs_val     = 32'($urandom_range(0, 3)) << 2;
            rt_val     = 32'($urandom_range(0, 3)) << 2;
            pc_cur     = $urandom;
            imm16      = 16'($urandom);
            target26   = 26'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_redirect.md
Name: pc_redirect

Overview:
- Control-flow resolution block that sits between the decode stage and the program counter.
- Consumes decoded branch, jump and syscall information plus the current word-addressed PC.
- Drives the PC's load-enable (pc_bj), load value (pc_target) and halt inputs.
- Sequences the pipeline squash after a taken redirect, holds the machine halted until resumed, and counts taken redirects.

Parameters:
- WORD_SIZE, 32, width of PC, register values and targets.
- FLUSH_CYCLES, 1, number of cycles the squash lasts after a taken redirect; legal range 1..15.
- HALT_CODE, 10, value of v0_val that makes a syscall request halt.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- pc_cur  in  WORD_SIZE  current PC, word address, from the program counter.
- id_valid  in  1  decode-stage instruction is valid.
- is_beq  in  1  decoded beq.
- is_bne  in  1  decoded bne.
- is_j  in  1  decoded j.
- is_jal  in  1  decoded jal.
- is_jr  in  1  decoded jr.
- is_syscall  in  1  decoded syscall.
- rs_val  in  WORD_SIZE  rs operand.
- rt_val  in  WORD_SIZE  rt operand.
- v0_val  in  WORD_SIZE  value of register $v0.
- imm16  in  16  branch offset in words.
- target26  in  26  jump target field.
- resume  in  1  single-cycle pulse that releases halt.
- pc_bj  out  1  PC load enable; combinational.
- pc_target  out  WORD_SIZE  PC load value; combinational.
- halt  out  1  freeze PC and cycle counting; registered.
- flush  out  1  squash the fetch and decode stages; registered.
- link_we  out  1  write $ra pulse; registered.
- link_addr  out  WORD_SIZE  value to write to $ra; registered.
- branch_count  out  32  count of taken redirects; registered.

Behaviour:
- Reset: rst is synchronous, active-high, on clk. It overrides all other inputs.
  - State goes to RUN.
  - halt, flush and link_we go to 0; link_addr and branch_count go to 0.
  - An internal flush counter goes to 0.
  - pc_bj=0 and pc_target=0 while rst is high.
- States: RUN, FLUSH, HALTED.
- Accepted instruction: id_valid=1 and state==RUN. In any other state the decode inputs are ignored and pc_bj=0.
- Decode priority, when several flags are set: syscall > jr > j/jal > beq/bne.
- Halting syscall: is_syscall and v0_val==HALT_CODE.
  - Takes priority over any redirect flag; pc_bj=0 in that cycle.
  - Next edge: halt=1, state=HALTED.
- Non-halting syscall (v0_val != HALT_CODE): no effect.
- Target computation, all arithmetic mod 2^WORD_SIZE:
  - pc1 = pc_cur+1.
  - beq/bne target = pc1 + sign_extend(imm16).
  - j/jal target = {pc1[WORD_SIZE-1:26], target26}.
  - jr target = {2'b00, rs_val[WORD_SIZE-1:2]}; register values are byte addresses.
- Taken condition:
  - beq taken if rs_val==rt_val; bne taken if they differ.
  - j, jal and jr are always taken.
- On an accepted taken redirect:
  - Same cycle: pc_bj=1, pc_target=target.
  - Next edge: flush=1, flush counter=FLUSH_CYCLES-1, state=FLUSH, and branch_count increments, saturating at 32'hFFFFFFFF.
- When no redirect is taken: pc_bj=0 and pc_target=pc1.
- jal: next edge link_we=1 for exactly one cycle, link_addr=pc1. link_addr holds its value afterwards.
- FLUSH state:
  - flush stays 1.
  - Each cycle: if the counter is 0, next edge state=RUN and flush=0; otherwise the counter decrements.
  - Total flush high time is exactly FLUSH_CYCLES cycles.
  - A syscall or branch presented during FLUSH is squashed: no halt, no count.
- HALTED state:
  - halt stays 1 and pc_bj=0.
  - resume=1: next edge halt=0, state=RUN.
  - resume outside HALTED is ignored.
- Reset mid-operation: rst during FLUSH or HALTED returns to RUN with all outputs cleared at that edge. No residual flush or halt remains.

Test Plan:
- Reset, then pc_cur=5, id_valid=1 with no flags -> pc_bj=0, pc_target=6, halt=0, flush=0, branch_count=0.
- beq with rs_val=rt_val=7, pc_cur=0x10, imm16=0xFFFE -> same cycle pc_bj=1, pc_target=0x0F; flush=1 for exactly FLUSH_CYCLES cycles; branch_count=1. bne with the same operands -> pc_bj=0, count unchanged.
- jal with pc_cur=0x0400_0003, target26=0x0000123 -> pc_target=0x0400_0123; link_we=1 for one cycle with link_addr=0x0400_0004. jr with rs_val=0x40 -> pc_target=0x10.
- Syscall with v0_val=10 and is_j both set -> pc_bj=0; halt=1 from the next edge. Hold 20 cycles -> halt stays 1 and id inputs are ignored. resume pulse -> halt=0 one edge later. Syscall with v0_val=4 -> no halt.
- Taken branch followed on the next cycle by a halting syscall in FLUSH -> syscall squashed, halt stays 0. With FLUSH_CYCLES=3 -> flush high exactly 3 cycles.
- rst asserted while HALTED, and separately mid-FLUSH -> next edge: halt=0, flush=0, branch_count=0, state RUN. Force branch_count to 0xFFFFFFFF, then a taken jump -> count stays 0xFFFFFFFF.
